// File: rtl/sound_comm_mailbox.sv
// Bidirectional nibble-serial mailbox between the main CPU and the sound CPU, with flags, sub-reset, NMI gating and ROM bank.
// Optional sticky overrun status per direction is enabled by defining SOUND_COMM_OVERRUN_EN.
module sound_comm_mailbox #(
  parameter int NIB_W  = 4,
  parameter int DATA_W = 16,
  parameter int BANK_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_wr,
  input  logic              m_rd,
  input  logic              m_a1,
  input  logic [NIB_W-1:0]  m_din,
  output logic [NIB_W-1:0]  m_dout,
  input  logic              s_wr,
  input  logic              s_rd,
  input  logic              s_a0,
  input  logic [NIB_W-1:0]  s_din,
  output logic [NIB_W-1:0]  s_dout,
  input  logic              s_bank_we,
  output logic [BANK_W-1:0] rom_bank,
  output logic              sub_reset,
  output logic              s_nmi
);

  localparam int NIBS     = DATA_W / NIB_W;
  localparam int GRPS     = NIBS / 2;
  localparam int IDX_NEED = $clog2(NIBS + 3);
  localparam int IDX_W    = (NIB_W > IDX_NEED) ? NIB_W : IDX_NEED;
  localparam logic [IDX_W-1:0] IDX_STAT   = IDX_W'(NIBS);
  localparam logic [IDX_W-1:0] IDX_NMI_ON = IDX_W'(NIBS + 1);
`ifdef SOUND_COMM_OVERRUN_EN
  localparam logic [IDX_W-1:0] IDX_OVR    = IDX_W'(NIBS + 2);
`endif

  logic [IDX_W-1:0]  m_idx_q, m_idx_d, s_idx_q, s_idx_d;
  logic [DATA_W-1:0] m2s_q, m2s_d, s2m_q, s2m_d;
  logic [GRPS-1:0]   m2s_flag_q, m2s_flag_d, s2m_flag_q, s2m_flag_d;
  logic [GRPS-1:0]   m2s_set, m2s_clr, s2m_set, s2m_clr;
  logic [NIB_W-1:0]  m_dout_q, m_dout_d, s_dout_q, s_dout_d;
  logic [NIB_W-1:0]  m_rd_val, s_rd_val, status;
  logic [BANK_W-1:0] rom_bank_q, rom_bank_d;
  logic              sub_reset_q, sub_reset_d, nmi_en_q, nmi_en_d;

  logic m_idx_wr, m_data_wr, m_data_rd, s_idx_wr, s_data_wr, s_data_rd;
  assign m_idx_wr  = m_wr & ~m_a1;
  assign m_data_wr = m_wr & m_a1;
  assign m_data_rd = m_rd & m_a1;
  assign s_idx_wr  = s_wr & ~s_a0;
  assign s_data_wr = s_wr & s_a0;
  assign s_data_rd = s_rd & s_a0;

`ifdef SOUND_COMM_OVERRUN_EN
  logic             m2s_ovr_q, m2s_ovr_d, s2m_ovr_q, s2m_ovr_d;
  logic [NIB_W-1:0] ovr_nib;

  // Each overrun bit is cleared only by the side that consumes that direction.
  always_comb begin
    ovr_nib      = '0;
    ovr_nib[1:0] = {s2m_ovr_q, m2s_ovr_q};
    m2s_ovr_d    = (m2s_ovr_q & ~(s_data_rd && (s_idx_q == IDX_OVR))) | (|(m2s_set & m2s_flag_q));
    s2m_ovr_d    = (s2m_ovr_q & ~(m_data_rd && (m_idx_q == IDX_OVR))) | (|(s2m_set & s2m_flag_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m2s_ovr_q <= 1'b0;
      s2m_ovr_q <= 1'b0;
    end else begin
      m2s_ovr_q <= m2s_ovr_d;
      s2m_ovr_q <= s2m_ovr_d;
    end
  end
`endif

  always_comb begin
    status                  = '0;
    status[GRPS-1:0]        = m2s_flag_q;
    status[2*GRPS-1:GRPS]   = s2m_flag_q;
  end

  // Main side: writes the main-to-sound message, reads the sound-to-main message.
  always_comb begin
    m_idx_d     = m_idx_q;
    m2s_d       = m2s_q;
    m2s_set     = '0;
    s2m_clr     = '0;
    m_rd_val    = '0;
    m_dout_d    = m_dout_q;
    sub_reset_d = sub_reset_q;
    if (m_idx_wr) begin
      m_idx_d = IDX_W'(m_din);
    end else if ((m_data_wr || m_data_rd) && (m_idx_q < IDX_STAT)) begin
      m_idx_d = m_idx_q + IDX_W'(1);
    end
    for (int i = 0; i < NIBS; i++) begin
      if (m_idx_q == IDX_W'(i)) begin
        if (m_data_wr) m2s_d[i*NIB_W +: NIB_W] = m_din;
        m_rd_val = s2m_q[i*NIB_W +: NIB_W];
      end
    end
    for (int g = 0; g < GRPS; g++) begin
      if (m_idx_q == IDX_W'(2*g + 1)) begin
        m2s_set[g] = m_data_wr;
        s2m_clr[g] = m_data_rd;
      end
    end
    if (m_data_wr && (m_idx_q == IDX_STAT)) sub_reset_d = m_din[0];
    if (m_idx_q == IDX_STAT) m_rd_val = status;
`ifdef SOUND_COMM_OVERRUN_EN
    if (m_idx_q == IDX_OVR) m_rd_val = ovr_nib;
`endif
    if (m_data_rd) m_dout_d = m_rd_val;
  end

  // Sound side: mirror of the main side, plus NMI enable control at NIBS / NIBS+1.
  always_comb begin
    s_idx_d  = s_idx_q;
    s2m_d    = s2m_q;
    s2m_set  = '0;
    m2s_clr  = '0;
    s_rd_val = '0;
    s_dout_d = s_dout_q;
    nmi_en_d = nmi_en_q;
    if (s_idx_wr) begin
      s_idx_d = IDX_W'(s_din);
    end else if ((s_data_wr || s_data_rd) && (s_idx_q < IDX_STAT)) begin
      s_idx_d = s_idx_q + IDX_W'(1);
    end
    for (int i = 0; i < NIBS; i++) begin
      if (s_idx_q == IDX_W'(i)) begin
        if (s_data_wr) s2m_d[i*NIB_W +: NIB_W] = s_din;
        s_rd_val = m2s_q[i*NIB_W +: NIB_W];
      end
    end
    for (int g = 0; g < GRPS; g++) begin
      if (s_idx_q == IDX_W'(2*g + 1)) begin
        s2m_set[g] = s_data_wr;
        m2s_clr[g] = s_data_rd;
      end
    end
    if (s_data_wr && (s_idx_q == IDX_STAT))   nmi_en_d = 1'b0;
    if (s_data_wr && (s_idx_q == IDX_NMI_ON)) nmi_en_d = 1'b1;
    if (s_idx_q == IDX_STAT) s_rd_val = status;
`ifdef SOUND_COMM_OVERRUN_EN
    if (s_idx_q == IDX_OVR) s_rd_val = ovr_nib;
`endif
    if (s_data_rd) s_dout_d = s_rd_val;
  end

  // A same-cycle set and clear of one flag resolves as set.
  always_comb begin
    m2s_flag_d = (m2s_flag_q & ~m2s_clr) | m2s_set;
    s2m_flag_d = (s2m_flag_q & ~s2m_clr) | s2m_set;
    rom_bank_d = s_bank_we ? s_din[BANK_W-1:0] : rom_bank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_idx_q     <= '0;
      s_idx_q     <= '0;
      m2s_q       <= '0;
      s2m_q       <= '0;
      m2s_flag_q  <= '0;
      s2m_flag_q  <= '0;
      m_dout_q    <= '0;
      s_dout_q    <= '0;
      rom_bank_q  <= '0;
      sub_reset_q <= 1'b0;
      nmi_en_q    <= 1'b0;
    end else begin
      m_idx_q     <= m_idx_d;
      s_idx_q     <= s_idx_d;
      m2s_q       <= m2s_d;
      s2m_q       <= s2m_d;
      m2s_flag_q  <= m2s_flag_d;
      s2m_flag_q  <= s2m_flag_d;
      m_dout_q    <= m_dout_d;
      s_dout_q    <= s_dout_d;
      rom_bank_q  <= rom_bank_d;
      sub_reset_q <= sub_reset_d;
      nmi_en_q    <= nmi_en_d;
    end
  end

  assign m_dout    = m_dout_q;
  assign s_dout    = s_dout_q;
  assign rom_bank  = rom_bank_q;
  assign sub_reset = sub_reset_q;
  assign s_nmi     = nmi_en_q & (|m2s_flag_q);

endmodule

// File: tb/tb_sound_comm_mailbox.sv
// Directed bench for sound_comm_mailbox; read results are scoreboarded through per-side expectation queues.
module tb_sound_comm_mailbox;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_wr, m_rd, m_a1, s_wr, s_rd, s_a0, s_bank_we;
  logic [3:0] m_din, s_din, m_dout, s_dout;
  logic [2:0] rom_bank;
  logic       sub_reset, s_nmi;

  int passed = 0;
  int total  = 0;
  logic [3:0] m_q[$];
  logic [3:0] s_q[$];

  sound_comm_mailbox #(.NIB_W(4), .DATA_W(16), .BANK_W(3)) dut (
    .clk(clk), .reset(reset),
    .m_wr(m_wr), .m_rd(m_rd), .m_a1(m_a1), .m_din(m_din), .m_dout(m_dout),
    .s_wr(s_wr), .s_rd(s_rd), .s_a0(s_a0), .s_din(s_din), .s_dout(s_dout),
    .s_bank_we(s_bank_we), .rom_bank(rom_bank), .sub_reset(sub_reset), .s_nmi(s_nmi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of strobes from a negedge; returns at the following negedge.
  task automatic step(input logic mw, input logic mr, input logic ma, input logic [3:0] md,
                      input logic sw, input logic sr, input logic sa, input logic [3:0] sd,
                      input logic bw, input logic rst);
    m_wr = mw; m_rd = mr; m_a1 = ma; m_din = md;
    s_wr = sw; s_rd = sr; s_a0 = sa; s_din = sd;
    s_bank_we = bw; reset = rst;
    @(negedge clk);
    m_wr = 1'b0; m_rd = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_bank_we = 1'b0; reset = 1'b0;
  endtask

  task automatic mwr(input logic a, input logic [3:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic swr(input logic a, input logic [3:0] d);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, a, d, 1'b0, 1'b0);
  endtask

  task automatic pop_m(input string tag);
    if (m_q.size() == 0) begin
      total++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else chk(tag, {4'h0, m_dout}, {4'h0, m_q.pop_front()});
  endtask

  task automatic pop_s(input string tag);
    if (s_q.size() == 0) begin
      total++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else chk(tag, {4'h0, s_dout}, {4'h0, s_q.pop_front()});
  endtask

  task automatic mrd(input string tag, input logic [3:0] exp);
    m_q.push_back(exp);
    step(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    pop_m(tag);
  endtask

  task automatic srd(input string tag, input logic [3:0] exp);
    s_q.push_back(exp);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    pop_s(tag);
  endtask

  initial begin
    logic [3:0] ovr_exp;
    m_wr = 0; m_rd = 0; m_a1 = 0; m_din = 0;
    s_wr = 0; s_rd = 0; s_a0 = 0; s_din = 0; s_bank_we = 0; reset = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_m_dout", {4'h0, m_dout}, 8'h0);
    chk("rst_s_dout", {4'h0, s_dout}, 8'h0);
    chk("rst_bank", {5'h0, rom_bank}, 8'h0);
    chk("rst_subrst", {7'h0, sub_reset}, 8'h0);
    chk("rst_nmi", {7'h0, s_nmi}, 8'h0);
    reset = 0;

    // Main sends 4,3,2,1; both flags set, NMI still gated off.
    mwr(0, 4'h0);
    mwr(1, 4'h4); mwr(1, 4'h3); mwr(1, 4'h2); mwr(1, 4'h1);
    mrd("m_status_full", 4'h3);
    chk("nmi_gated", {7'h0, s_nmi}, 8'h0);
    swr(0, 4'h5);
    swr(1, 4'h0);
    chk("nmi_enabled", {7'h0, s_nmi}, 8'h1);

    // Sound drains the message; flags clear per pair.
    swr(0, 4'h0);
    srd("s_rd0", 4'h4);
    srd("s_rd1", 4'h3);
    mrd("status_after_grp0", 4'h2);
    chk("nmi_mid", {7'h0, s_nmi}, 8'h1);
    srd("s_rd2", 4'h2);
    srd("s_rd3", 4'h1);
    chk("nmi_dropped", {7'h0, s_nmi}, 8'h0);
    mrd("status_drained", 4'h0);
    srd("s_status_drained", 4'h0);

    // Sound sends 0xBEEF, main reads it back.
    swr(0, 4'h0);
    swr(1, 4'hF); swr(1, 4'hE); swr(1, 4'hE); swr(1, 4'hB);
    mrd("m_status_s2m", 4'hC);
    mwr(0, 4'h0);
    mrd("m_rd0", 4'hF);
    mrd("m_rd1", 4'hE);
    mrd("m_rd2", 4'hE);
    mrd("m_rd3", 4'hB);
    mrd("m_status_after", 4'h0);
    mrd("m_status_again", 4'h0);

    // Sub reset control and ROM bank.
    mwr(1, 4'h1);
    chk("subrst_set", {7'h0, sub_reset}, 8'h1);
    mwr(1, 4'h0);
    chk("subrst_clr", {7'h0, sub_reset}, 8'h0);
    mrd("idx_held_at_status", 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hD, 1'b1, 1'b0);
    chk("rom_bank", {5'h0, rom_bank}, 8'h05);

    // Same-cycle set (main completes group 0) and clear (sound reads nibble 1).
    mwr(0, 4'h0);
    mwr(1, 4'h7); mwr(1, 4'h8);
    swr(0, 4'h0);
    srd("s_rd_pre", 4'h7);
    mwr(0, 4'h1);
    s_q.push_back(4'h8);
    step(1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    pop_s("s_rd_collide");
    chk("nmi_set_wins", {7'h0, s_nmi}, 8'h1);
    mwr(0, 4'h4);
    mrd("status_set_wins", 4'h1);

    // Reset mid-message with competing strobes.
    mwr(1, 4'h1);
    chk("subrst_pre_rst", {7'h0, sub_reset}, 8'h1);
    mwr(0, 4'h0);
    mwr(1, 4'h5);
    step(1'b1, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1);
    chk("mid_rst_m_dout", {4'h0, m_dout}, 8'h0);
    chk("mid_rst_s_dout", {4'h0, s_dout}, 8'h0);
    chk("mid_rst_bank", {5'h0, rom_bank}, 8'h0);
    chk("mid_rst_subrst", {7'h0, sub_reset}, 8'h0);
    chk("mid_rst_nmi", {7'h0, s_nmi}, 8'h0);
    mrd("mid_rst_s2m_data", 4'h0);
    swr(0, 4'h4);
    srd("mid_rst_status", 4'h0);

    // Two full messages with no sound read in between.
    for (int pass = 0; pass < 2; pass++) begin
      mwr(0, 4'h0);
      for (int n = 0; n < 4; n++) mwr(1, 4'(pass * 4 + n + 1));
    end
`ifdef SOUND_COMM_OVERRUN_EN
    ovr_exp = 4'h1;
`else
    ovr_exp = 4'h0;
`endif
    swr(0, 4'h6);
    srd("ovr_first", ovr_exp);
    srd("ovr_cleared", 4'h0);
    mwr(0, 4'h6);
    mrd("m_ovr", 4'h0);
    mwr(0, 4'h0);
    mrd("s2m_after_ovr", 4'h0);
    swr(0, 4'h0);
    srd("m2s_latest", 4'h5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
